// File: rtl/ch_leaky_integrator.sv
// Per-channel leaky integrator: y += (x - y) >>> mu over a 4-state
// multicycle datapath, with a packed status word for a PIO input port.
module ch_leaky_integrator (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               sample_valid,
  input  logic signed [15:0] sample_data,
  output logic               sample_ready,
  input  logic        [3:0]  mu_shift,
  output logic        [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIFF,
    S_SCALE,
    S_UPDATE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [15:0] r_x;
  logic        [3:0]  r_mu;
  logic signed [16:0] r_diff;
  logic signed [15:0] r_scaled;
  logic signed [15:0] r_y;
  logic        [7:0]  r_seq;
  logic        [6:0]  r_drops;
  logic               r_strobe;

  logic w_accept;
  logic w_drop;

  assign sample_ready = (r_state == S_IDLE);
  assign w_accept = sample_valid & sample_ready & ~clear;
  assign w_drop   = sample_valid & ~sample_ready & ~clear;
  assign result   = {r_strobe, r_drops, r_seq, r_y};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (w_accept) w_next = S_DIFF;
        S_DIFF:   w_next = S_SCALE;
        S_SCALE:  w_next = S_UPDATE;
        S_UPDATE: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Result lies between old y and x, so the 16-bit truncation is exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x      <= '0;
      r_mu     <= '0;
      r_diff   <= '0;
      r_scaled <= '0;
      r_y      <= '0;
      r_seq    <= '0;
      r_drops  <= '0;
      r_strobe <= 1'b0;
    end else if (clear) begin
      r_x      <= '0;
      r_mu     <= '0;
      r_diff   <= '0;
      r_scaled <= '0;
      r_y      <= '0;
      r_seq    <= '0;
      r_drops  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_drop && r_drops != 7'd127)
        r_drops <= r_drops + 7'd1;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x  <= sample_data;
            r_mu <= mu_shift;
          end
        end
        S_DIFF: begin
          r_diff <= {r_x[15], r_x} - {r_y[15], r_y};
        end
        S_SCALE: begin
          r_scaled <= 16'(r_diff >>> r_mu);
        end
        S_UPDATE: begin
          r_y      <= r_y + r_scaled;
          r_seq    <= r_seq + 8'd1;
          r_strobe <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
